// File: rtl/mc10_latch_sequencer.sv
// Keyed command sequencer replacing the legacy 6-bit VDG/control latch.
// Clocked by CPU writes to the latch region; every edge is one write.
module mc10_latch_sequencer #(
  parameter logic [7:0]  KEY0   = 8'hA5,
  parameter logic [7:0]  KEY1   = 8'h5A,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned PAGE_W = 4
) (
  input  logic              U8_clock,
  input  logic              RESET,
  input  logic [7:0]        din,
  output logic [5:0]        vdg_ctrl,
  output logic [BANK_W-1:0] bank_sel,
  output logic [PAGE_W-1:0] vdg_page,
  output logic              ext_en,
  output logic              cmd_mode,
  output logic              err,
  output logic [3:0]        cmd_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    K1       = 3'd1,
    CMD      = 3'd2,
    ARG_BANK = 3'd3,
    ARG_PAGE = 3'd4,
    ARG_EN   = 3'd5
  } state_t;

  state_t     state;
  logic [3:0] opcode;

  assign opcode = din[7:4];

  // Key detection, opcode decode and argument capture; all outputs registered.
  always_ff @(posedge U8_clock or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      vdg_ctrl <= 6'd0;
      bank_sel <= '0;
      vdg_page <= '0;
      ext_en   <= 1'b0;
      cmd_mode <= 1'b0;
      err      <= 1'b0;
      cmd_cnt  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          vdg_ctrl <= din[7:2];
          cmd_mode <= 1'b0;
          state    <= (din == KEY0) ? K1 : IDLE;
        end
        // Key bytes still reach the VDG so legacy software sees a plain latch.
        K1: begin
          vdg_ctrl <= din[7:2];
          if (din == KEY1) begin
            state    <= CMD;
            cmd_mode <= 1'b1;
          end else if (din == KEY0) begin
            state    <= K1;
            cmd_mode <= 1'b0;
          end else begin
            state    <= IDLE;
            cmd_mode <= 1'b0;
          end
        end
        CMD: begin
          cmd_mode <= 1'b1;
          case (opcode)
            4'h1: state <= ARG_BANK;
            4'h2: state <= ARG_PAGE;
            4'h3: state <= ARG_EN;
            4'h4: begin
              bank_sel <= '0;
              vdg_page <= '0;
              cmd_cnt  <= cmd_cnt + 4'd1;
            end
            4'h5: begin
              err     <= 1'b0;
              cmd_cnt <= cmd_cnt + 4'd1;
            end
            4'hF: begin
              state    <= IDLE;
              cmd_mode <= 1'b0;
            end
            default: err <= 1'b1;
          endcase
        end
        // Argument bytes are taken verbatim, never decoded as opcodes.
        ARG_BANK: begin
          bank_sel <= din[BANK_W-1:0];
          cmd_cnt  <= cmd_cnt + 4'd1;
          cmd_mode <= 1'b1;
          state    <= CMD;
        end
        ARG_PAGE: begin
          vdg_page <= din[PAGE_W-1:0];
          cmd_cnt  <= cmd_cnt + 4'd1;
          cmd_mode <= 1'b1;
          state    <= CMD;
        end
        ARG_EN: begin
          ext_en   <= din[0];
          cmd_cnt  <= cmd_cnt + 4'd1;
          cmd_mode <= 1'b1;
          state    <= CMD;
        end
        default: begin
          state    <= IDLE;
          cmd_mode <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc10_latch_sequencer.sv
// Directed-vector bench for mc10_latch_sequencer with hand-computed expectations.
module tb_mc10_latch_sequencer;

  logic       U8_clock;
  logic       RESET;
  logic [7:0] din;
  logic [5:0] vdg_ctrl;
  logic [1:0] bank_sel;
  logic [3:0] vdg_page;
  logic       ext_en;
  logic       cmd_mode;
  logic       err;
  logic [3:0] cmd_cnt;

  int tests_run;
  int tests_failed;

  mc10_latch_sequencer #(
    .KEY0  (8'hA5),
    .KEY1  (8'h5A),
    .BANK_W(2),
    .PAGE_W(4)
  ) dut (
    .U8_clock(U8_clock),
    .RESET   (RESET),
    .din     (din),
    .vdg_ctrl(vdg_ctrl),
    .bank_sel(bank_sel),
    .vdg_page(vdg_page),
    .ext_en  (ext_en),
    .cmd_mode(cmd_mode),
    .err     (err),
    .cmd_cnt (cmd_cnt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One CPU write: data set up, strobe pulse, outputs sampled after the falling edge.
  task automatic write_byte(input logic [7:0] b);
    din = b;
    #5 U8_clock = 1'b1;
    #5 U8_clock = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    #3 RESET = 1'b0;
    #2;
  endtask

  task automatic check_all(input string tag, input logic [5:0] v, input logic [1:0] b,
                           input logic [3:0] p, input logic e, input logic m,
                           input logic er, input logic [3:0] c);
    check({tag, ".vdg"},  8'(vdg_ctrl), 8'(v));
    check({tag, ".bank"}, 8'(bank_sel), 8'(b));
    check({tag, ".page"}, 8'(vdg_page), 8'(p));
    check({tag, ".ext"},  8'(ext_en),   8'(e));
    check({tag, ".mode"}, 8'(cmd_mode), 8'(m));
    check({tag, ".err"},  8'(err),      8'(er));
    check({tag, ".cnt"},  8'(cmd_cnt),  8'(c));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    U8_clock     = 1'b0;
    din          = 8'h00;
    RESET        = 1'b0;
    do_reset();
    check_all("reset", 6'h00, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Legacy latch write
    write_byte(8'hC4);
    check_all("legacy", 6'h31, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Unlock and set bank
    write_byte(8'hA5);
    check("k1.vdg", 8'(vdg_ctrl), 8'h29);
    check("k1.mode", 8'(cmd_mode), 8'h0);
    write_byte(8'h5A);
    check("unlock.mode", 8'(cmd_mode), 8'h1);
    check("unlock.vdg", 8'(vdg_ctrl), 8'h16);
    write_byte(8'h10);
    check("argbank.mode", 8'(cmd_mode), 8'h1);
    write_byte(8'h03);
    check_all("bank", 6'h16, 2'd3, 4'h0, 1'b0, 1'b1, 1'b0, 4'd1);

    // Repeated KEY0, page, ext enable, exit
    do_reset();
    write_byte(8'hA5);
    write_byte(8'hA5);
    write_byte(8'h5A);
    check("rekey.mode", 8'(cmd_mode), 8'h1);
    write_byte(8'h20);
    write_byte(8'h07);
    write_byte(8'h30);
    write_byte(8'h01);
    write_byte(8'hF0);
    check_all("exit", 6'h16, 2'd0, 4'h7, 1'b1, 1'b0, 1'b0, 4'd2);
    write_byte(8'h80);
    check_all("post_exit", 6'h20, 2'd0, 4'h7, 1'b1, 1'b0, 1'b0, 4'd2);

    // Broken key
    write_byte(8'hA5);
    write_byte(8'h33);
    check("badkey.vdg", 8'(vdg_ctrl), 8'h0C);
    check("badkey.mode", 8'(cmd_mode), 8'h0);
    write_byte(8'h5A);
    check("nounlock.mode", 8'(cmd_mode), 8'h0);
    check("nounlock.vdg", 8'(vdg_ctrl), 8'h16);

    // Illegal opcode, err clear, F2 taken verbatim as bank argument
    write_byte(8'hA5);
    write_byte(8'h5A);
    write_byte(8'h70);
    check("illegal.err", 8'(err), 8'h1);
    check("illegal.mode", 8'(cmd_mode), 8'h1);
    check("illegal.cnt", 8'(cmd_cnt), 8'd2);
    write_byte(8'h50);
    check("clrerr.err", 8'(err), 8'h0);
    check("clrerr.cnt", 8'(cmd_cnt), 8'd3);
    write_byte(8'h10);
    write_byte(8'hF2);
    check_all("argF2", 6'h16, 2'd2, 4'h7, 1'b1, 1'b1, 1'b0, 4'd4);
    write_byte(8'h40);
    check_all("op4", 6'h16, 2'd0, 4'h0, 1'b1, 1'b1, 1'b0, 4'd5);

    // Reset mid-command, asynchronous with no clock edge
    write_byte(8'h10);
    RESET = 1'b1;
    #2;
    check_all("async_rst", 6'h00, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);
    RESET = 1'b0;
    #2;
    write_byte(8'h03);
    check_all("after_rst", 6'h00, 2'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0);

    // cmd_cnt wraps 15 -> 0
    write_byte(8'hA5);
    write_byte(8'h5A);
    for (int i = 0; i < 15; i++) write_byte(8'h50);
    check("cnt15", 8'(cmd_cnt), 8'd15);
    write_byte(8'h50);
    check("cnt_wrap", 8'(cmd_cnt), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
